vx_dcache_responder: RTL and testbench
======================================

// Module: vx_dcache_responder
// PURPOSE
//  Banked scratchpad acting as the responder end of the per-lane dcache request/response protocol driven by the LSU.
//  Accepts NUM_THREADS lane requests per cycle, serialises bank conflicts, commits writes and returns one merged
//  read response per grant cycle, carrying a thread mask and the requester tag. Sits in the SM/local-memory path of a core.
// PARAMETERS
//  NUM_THREADS  4     lanes per request
//  NUM_BANKS    4     power of 2; bank = word_addr[log2(NUM_BANKS)-1:0]
//  WORDS        1024  total 32-bit words (power of 2, multiple of NUM_BANKS); row = next log2(WORDS/NUM_BANKS) addr bits
//  ADDRW        30    word-address width; upper bits ignored
//  TAGW         16    tag width
//  RSPQ_SIZE    4     response queue depth (>=2)
// PORTS
//  clk            in   1              clock
//  reset          in   1              asynchronous, active-high
//  req_valid      in   NUM_THREADS    per-lane request valid
//  req_rw         in   NUM_THREADS    1 = write, 0 = read
//  req_addr       in   NUM_THREADS*ADDRW  word address
//  req_byteen     in   NUM_THREADS*4  byte enables (writes)
//  req_data       in   NUM_THREADS*32 write data
//  req_tag        in   NUM_THREADS*TAGW  per-lane tag
//  req_ready      out  NUM_THREADS    lane granted this cycle (fire = valid & ready)
//  rsp_valid      out  1              response valid
//  rsp_tmask      out  NUM_THREADS    lanes carried by response
//  rsp_data       out  NUM_THREADS*32 read data, valid for rsp_tmask lanes, 0 elsewhere
//  rsp_tag        out  TAGW           tag of lowest lane in rsp_tmask
//  rsp_ready      in   1              consumer accepts response
//  perf_conflicts out  32             cycles in which >=1 valid lane was not granted
// BEHAVIOUR
//  Grant (combinational, stage 0):
//   - lead = lowest lane with req_valid; eligible lanes: valid, same rw and same tag as lead.
//   - per bank, grant the lowest-index eligible lane; req_ready[i] = granted. Others retry later (not dropped).
//   - read group granted only if credits > 0; else req_ready = 0 for all lanes that cycle (writes also held if lead is read).
//   - req_ready is combinational from req_* and credits; no dependence on rsp_ready in the same cycle.
//  Writes: commit at clock edge of grant, per byte per byteen; no response generated.
//  Reads: memory read at grant edge; stage 1 register holds {tmask, data, tag}; pushed into RSPQ next edge.
//   - read-to-rsp_valid latency = 2 cycles when queue empty; rsp is queue head (FIFO order).
//  Credits: init RSPQ_SIZE; -1 on read grant, +1 on rsp pop (rsp_valid & rsp_ready); both same cycle = unchanged.
//   Never negative/overflow; full queue back-pressures requests, never drops responses.
//  Same-cycle write then read of the same word in a later cycle returns new data; within one cycle only one rw kind.
//  Reset (async): rsp_valid=0, rsp_tmask=0, rsp_tag=0, rsp_data=0, req_ready=0 while reset high, credits=RSPQ_SIZE,
//   queue and stage 1 emptied, perf_conflicts=0. Memory contents not reset. In-flight reads at reset are discarded.
//  perf_conflicts wraps at 2^32.
// TESTING
//  1. Write 0xA5A5A5A5 to lanes 0-3 at addr 0,1,2,3 (distinct banks) -> all req_ready=1 one cycle; read back tag 0x12,
//     tmask 4'b1111 -> rsp_valid 2 cycles later, data all 0xA5A5A5A5, rsp_tag 0x12.
//  2. Read lanes 0,2 addr 4 and 8 (both bank 0) -> cycle 0 grants lane 0, cycle 1 lane 2; two responses tmask 0001 then
//     0100; perf_conflicts = 1.
//  3. Byte write byteen 4'b0010 data 0x0000BB00 to word holding 0x11223344 -> readback 0x1122BB44.
//  4. rsp_ready=0, issue RSPQ_SIZE+1 single-lane reads -> first RSPQ_SIZE granted, next req_ready=0; raise rsp_ready
//     -> responses in order, held read granted after first pop.
//  5. Mixed cycle: lane 0 read tag 1, lane 1 write, lane 2 read tag 2 -> only lane 0 granted; remaining lanes in later cycles.
//  6. Assert reset with 2 reads in flight -> rsp_valid drops immediately, no stale response after release, credits full.

Source files
------------

// File: rtl/vx_dcache_responder.sv
// vx_dcache_responder
// Banked scratchpad that answers the per-lane dcache request/response protocol
// driven by the LSU. Each cycle it grants at most one lane per bank from a
// group of lanes that share the lead lane's rw kind and tag. Writes commit at
// the grant edge. Reads are merged into one response per grant cycle. These
// responses pass through a one-entry stage register into an in-order response
// queue.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   req_valid/ready   per-lane request handshake (fire = valid & ready)
//   req_rw            per-lane 1 = write, 0 = read
//   req_addr          per-lane word address (upper bits ignored)
//   req_byteen        per-lane byte enables for writes
//   req_data          per-lane write data
//   req_tag           per-lane requester tag
//   rsp_valid/ready   response handshake
//   rsp_tmask         lanes carried by the response
//   rsp_data          per-lane read data, zero outside rsp_tmask
//   rsp_tag           tag of the lowest lane in rsp_tmask
//   perf_conflicts    cycles in which some valid lane was not granted
module vx_dcache_responder #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_BANKS   = 4,
  parameter int WORDS       = 1024,
  parameter int ADDRW       = 30,
  parameter int TAGW        = 16,
  parameter int RSPQ_SIZE   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_THREADS-1:0]    req_valid,
  input  logic [NUM_THREADS-1:0]    req_rw,
  input  logic [NUM_THREADS*ADDRW-1:0] req_addr,
  input  logic [NUM_THREADS*4-1:0]  req_byteen,
  input  logic [NUM_THREADS*32-1:0] req_data,
  input  logic [NUM_THREADS*TAGW-1:0] req_tag,
  output logic [NUM_THREADS-1:0]    req_ready,
  output logic                      rsp_valid,
  output logic [NUM_THREADS-1:0]    rsp_tmask,
  output logic [NUM_THREADS*32-1:0] rsp_data,
  output logic [TAGW-1:0]           rsp_tag,
  input  logic                      rsp_ready,
  output logic [31:0]               perf_conflicts
);

  localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int WORD_W  = $clog2(WORDS);
  localparam int QPTR_W  = (RSPQ_SIZE > 1) ? $clog2(RSPQ_SIZE) : 1;
  localparam int CNT_W   = $clog2(RSPQ_SIZE + 1);
  localparam int LDATA_W = NUM_THREADS * 32;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] w;
    w = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) w[8*b +: 8] = new_w[8*b +: 8];
    end
    return w;
  endfunction

  function automatic logic [QPTR_W-1:0] ptr_inc(input logic [QPTR_W-1:0] p);
    if (p == QPTR_W'(RSPQ_SIZE - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Word index is {row, bank}, so a flat array holds all banks; bank
  // conflicts are resolved by the grant logic, not by the storage.
  logic [31:0] mem [WORDS];

  // Address bits above the word index are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  logic                   lead_found_p0;
  logic                   lead_rw_p0;
  logic [TAGW-1:0]        lead_tag_p0;
  logic [NUM_THREADS-1:0] grant_p0;
  logic [NUM_BANKS-1:0]   bank_busy_p0;
  logic                   hold_p0;
  logic                   rd_fire_p0;
  logic                   conflict_p0;
  logic                   pop;

  logic                   vld_p1;
  logic [NUM_THREADS-1:0] tmask_p1;
  logic [LDATA_W-1:0]     data_p1;
  logic [TAGW-1:0]        tag_p1;

  logic [NUM_THREADS-1:0] q_tmask [RSPQ_SIZE];
  logic [LDATA_W-1:0]     q_data  [RSPQ_SIZE];
  logic [TAGW-1:0]        q_tag   [RSPQ_SIZE];
  logic [QPTR_W-1:0]      wr_ptr;
  logic [QPTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]       q_count;
  logic [CNT_W-1:0]       credits;

  // ---- stage 0: lead selection and per-bank grant ----
  always_comb begin
    lead_found_p0 = 1'b0;
    lead_rw_p0    = 1'b0;
    lead_tag_p0   = '0;
    grant_p0      = '0;
    bank_busy_p0  = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (req_valid[i] && !lead_found_p0) begin
        lead_found_p0 = 1'b1;
        lead_rw_p0    = req_rw[i];
        lead_tag_p0   = req_tag[i*TAGW +: TAGW];
      end
    end
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (req_valid[i] && (req_rw[i] == lead_rw_p0) &&
          (req_tag[i*TAGW +: TAGW] == lead_tag_p0) &&
          !bank_busy_p0[req_addr[i*ADDRW +: BANK_W]]) begin
        grant_p0[i] = 1'b1;
        bank_busy_p0[req_addr[i*ADDRW +: BANK_W]] = 1'b1;
      end
    end
  end

  // A read group with no queue credit stalls every lane, including writes
  // queued behind the read lead, so that responses are never dropped.
  assign hold_p0     = lead_found_p0 && !lead_rw_p0 && (credits == '0);
  assign req_ready   = (reset || hold_p0) ? '0 : grant_p0;
  assign rd_fire_p0  = (|req_ready) && !lead_rw_p0;
  assign conflict_p0 = |(req_valid & ~req_ready);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (req_ready[i] && req_rw[i]) begin
        mem[req_addr[i*ADDRW +: WORD_W]] <= merge_bytes(mem[req_addr[i*ADDRW +: WORD_W]],
                                                        req_data[i*32 +: 32],
                                                        req_byteen[i*4 +: 4]);
      end
      if (rd_fire_p0) data_p1[i*32 +: 32] <= mem[req_addr[i*ADDRW +: WORD_W]];
    end
    if (rd_fire_p0) begin
      tmask_p1 <= req_ready;
      tag_p1   <= lead_tag_p0;
    end
  end

  // ---- stage 1 -> response queue ----
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      q_tmask[wr_ptr] <= tmask_p1;
      q_data[wr_ptr]  <= data_p1;
      q_tag[wr_ptr]   <= tag_p1;
    end
  end

  assign rsp_valid = (q_count != '0);
  assign pop       = rsp_valid && rsp_ready;

  // Credits track free queue slots minus reads already in flight, so a push
  // from stage 1 always finds room.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1         <= 1'b0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      q_count        <= '0;
      credits        <= CNT_W'(RSPQ_SIZE);
      perf_conflicts <= '0;
    end else begin
      vld_p1 <= rd_fire_p0;
      if (vld_p1) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      q_count <= q_count + CNT_W'(vld_p1) - CNT_W'(pop);
      credits <= credits - CNT_W'(rd_fire_p0) + CNT_W'(pop);
      if (conflict_p0) perf_conflicts <= perf_conflicts + 32'd1;
    end
  end

  // ---- queue head -> response outputs ----
  always_comb begin
    rsp_tmask = '0;
    rsp_tag   = '0;
    rsp_data  = '0;
    if (rsp_valid) begin
      rsp_tmask = q_tmask[rd_ptr];
      rsp_tag   = q_tag[rd_ptr];
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (q_tmask[rd_ptr][i]) rsp_data[i*32 +: 32] = q_data[rd_ptr][i*32 +: 32];
      end
    end
  end

endmodule

// File: tb/tb_vx_dcache_responder.sv
// tb_vx_dcache_responder
// Directed and randomized stimulus for vx_dcache_responder. A word-level
// memory model and a queue of expected responses predict grants, response
// contents, response timing and the conflict counter.
module tb_vx_dcache_responder;
  localparam int NT = 4;
  localparam int NB = 4;
  localparam int WORDS = 1024;
  localparam int ADDRW = 30;
  localparam int TAGW = 16;
  localparam int QS = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NT-1:0] req_valid, req_rw, req_ready;
  logic [NT*ADDRW-1:0] req_addr;
  logic [NT*4-1:0] req_byteen;
  logic [NT*32-1:0] req_data, rsp_data;
  logic [NT*TAGW-1:0] req_tag;
  logic rsp_valid, rsp_ready;
  logic [NT-1:0] rsp_tmask;
  logic [TAGW-1:0] rsp_tag;
  logic [31:0] perf_conflicts;

  vx_dcache_responder #(.NUM_THREADS(NT), .NUM_BANKS(NB), .WORDS(WORDS),
                        .ADDRW(ADDRW), .TAGW(TAGW), .RSPQ_SIZE(QS)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_byteen(req_byteen), .req_data(req_data),
    .req_tag(req_tag), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_tmask(rsp_tmask), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_ready(rsp_ready), .perf_conflicts(perf_conflicts));

  always #5 clk = ~clk;

  typedef struct {
    logic [NT-1:0]    tmask;
    logic [NT*32-1:0] data;
    logic [TAGW-1:0]  tag;
    int               rdy;
  } rsp_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] perf_m = '0;
  logic [31:0] mmem [WORDS];
  rsp_t q[$];
  logic [NT-1:0] obs_ready;
  logic obs_valid;
  logic [NT*32-1:0] last_data;
  logic [TAGW-1:0] last_tag;
  logic [NT-1:0] last_tmask;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant rule: lead = lowest valid lane; eligible = same rw and tag as lead;
  // lowest eligible lane per bank wins; reads need a free response slot.
  function automatic logic [NT-1:0] model_grant();
    logic [NT-1:0] g;
    logic [NB-1:0] used;
    int lead;
    int b;
    g = '0;
    used = '0;
    lead = -1;
    for (int i = NT - 1; i >= 0; i--) if (req_valid[i]) lead = i;
    if (lead < 0) return '0;
    if (!req_rw[lead] && (QS - q.size()) == 0) return '0;
    for (int i = 0; i < NT; i++) begin
      if (req_valid[i] && req_rw[i] == req_rw[lead] &&
          req_tag[i*TAGW +: TAGW] == req_tag[lead*TAGW +: TAGW]) begin
        b = int'(req_addr[i*ADDRW +: ADDRW]) % NB;
        if (!used[b]) begin
          used[b] = 1'b1;
          g[i] = 1'b1;
        end
      end
    end
    return g;
  endfunction

  task automatic apply_grant(input logic [NT-1:0] g);
    int lead;
    int w;
    rsp_t e;
    lead = 0;
    for (int i = NT - 1; i >= 0; i--) if (g[i]) lead = i;
    if (req_rw[lead]) begin
      for (int i = 0; i < NT; i++) begin
        if (g[i]) begin
          w = int'(req_addr[i*ADDRW +: ADDRW]) % WORDS;
          for (int k = 0; k < 4; k++)
            if (req_byteen[i*4 + k]) mmem[w][8*k +: 8] = req_data[i*32 + 8*k +: 8];
        end
      end
    end else begin
      e.tmask = g;
      e.tag = req_tag[lead*TAGW +: TAGW];
      e.data = '0;
      e.rdy = cyc + 2;
      for (int i = 0; i < NT; i++)
        if (g[i]) e.data[i*32 +: 32] = mmem[int'(req_addr[i*ADDRW +: ADDRW]) % WORDS];
      q.push_back(e);
    end
  endtask

  // One clock cycle: check at the falling edge, update the model after the
  // rising edge, retire fired lanes.
  task automatic step();
    logic [NT-1:0] g;
    logic head_vis;
    logic pop;
    @(negedge clk);
    g = model_grant();
    obs_ready = req_ready;
    obs_valid = rsp_valid;
    chk("req_ready", req_ready, g);
    chk("perf_conflicts", perf_conflicts, perf_m);
    head_vis = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("rsp_valid", rsp_valid, head_vis);
    if (head_vis) begin
      chk("rsp_tmask", rsp_tmask, q[0].tmask);
      chk("rsp_tag", rsp_tag, q[0].tag);
      chk("rsp_data", rsp_data, q[0].data);
    end
    pop = head_vis && rsp_ready;
    if (rsp_valid && rsp_ready) begin
      last_data = rsp_data;
      last_tag = rsp_tag;
      last_tmask = rsp_tmask;
    end
    @(posedge clk);
    #1;
    if (pop) q.delete(0);
    if (g != '0) apply_grant(g);
    if ((req_valid & ~g) != '0) perf_m = perf_m + 1;
    req_valid = req_valid & ~obs_ready;
    cyc++;
  endtask

  task automatic set_lane(input int i, input logic rw, input logic [ADDRW-1:0] addr,
                          input logic [3:0] be, input logic [31:0] data, input logic [TAGW-1:0] tag);
    req_valid[i] = 1'b1;
    req_rw[i] = rw;
    req_addr[i*ADDRW +: ADDRW] = addr;
    req_byteen[i*4 +: 4] = be;
    req_data[i*32 +: 32] = data;
    req_tag[i*TAGW +: TAGW] = tag;
  endtask

  task automatic issue(input int limit);
    int n;
    n = 0;
    while (req_valid != '0 && n < limit) begin
      step();
      n++;
    end
    chk("issue_timeout", req_valid, '0);
    req_valid = '0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    rsp_ready = 1'b1;
    while (q.size() > 0 && n < limit) begin
      step();
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] p0;
    logic [31:0] r;
    reset = 1'b1;
    req_valid = '0;
    req_rw = '0;
    req_addr = '0;
    req_byteen = '0;
    req_data = '0;
    req_tag = '0;
    rsp_ready = 1'b1;
    #2;
    req_valid = '1;
    #1;
    chk("reset_req_ready", req_ready, '0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_tmask", rsp_tmask, '0);
    chk("reset_rsp_tag", rsp_tag, '0);
    chk("reset_rsp_data", rsp_data, '0);
    chk("reset_perf", perf_conflicts, '0);
    req_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Full-width write to four banks, then a merged read back.
    for (int i = 0; i < NT; i++) set_lane(i, 1'b1, ADDRW'(i), 4'hF, 32'hA5A5A5A5, 16'h12);
    step();
    chk("t1_wr_ready", obs_ready, 4'hF);
    for (int i = 0; i < NT; i++) set_lane(i, 1'b0, ADDRW'(i), 4'h0, 32'h0, 16'h12);
    step();
    chk("t1_rd_ready", obs_ready, 4'hF);
    step();
    chk("t1_lat1_valid", obs_valid, 1'b0);
    step();
    chk("t1_lat2_valid", obs_valid, 1'b1);
    chk("t1_data", last_data, {4{32'hA5A5A5A5}});
    chk("t1_tag", last_tag, 16'h12);
    chk("t1_tmask", last_tmask, 4'hF);

    // Bank conflict on bank 0 between lanes 0 and 2.
    for (int i = 0; i < NT; i++) set_lane(i, 1'b1, ADDRW'(4 + i), 4'hF, 32'h4000_0000 + i, 16'h3);
    issue(4);
    for (int i = 0; i < NT; i++) set_lane(i, 1'b1, ADDRW'(8 + i), 4'hF, 32'h8000_0000 + i, 16'h3);
    issue(4);
    p0 = perf_conflicts;
    set_lane(0, 1'b0, 30'd4, 4'h0, 32'h0, 16'h5);
    set_lane(2, 1'b0, 30'd8, 4'h0, 32'h0, 16'h5);
    issue(8);
    drain(16);
    chk("t2_perf_delta", perf_conflicts - p0, 32'd1);
    chk("t2_last_tmask", last_tmask, 4'b0100);
    chk("t2_last_data", last_data[95:64], 32'h8000_0000);

    // Byte-enable merge.
    set_lane(0, 1'b1, 30'd12, 4'hF, 32'h11223344, 16'h0);
    issue(4);
    set_lane(1, 1'b1, 30'd12, 4'b0010, 32'h0000BB00, 16'h0);
    issue(4);
    set_lane(3, 1'b0, 30'd12, 4'h0, 32'h0, 16'h9);
    issue(4);
    drain(16);
    chk("t3_byte_merge", last_data[127:96], 32'h1122BB44);

    // Queue back-pressure.
    rsp_ready = 1'b0;
    for (int k = 0; k < QS; k++) begin
      set_lane(0, 1'b0, ADDRW'(k), 4'h0, 32'h0, 16'h40 + 16'(k));
      issue(4);
    end
    set_lane(0, 1'b0, 30'd4, 4'h0, 32'h0, 16'h44);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_held", obs_ready, 4'b0000);
    end
    rsp_ready = 1'b1;
    step();
    chk("t4_first_pop", last_tag, 16'h40);
    step();
    chk("t4_late_grant", obs_ready, 4'b0001);
    drain(32);
    chk("t4_last_tag", last_tag, 16'h44);

    // Mixed rw/tag group serialised over three cycles.
    set_lane(0, 1'b0, 30'd1, 4'h0, 32'h0, 16'h1);
    set_lane(1, 1'b1, 30'd5, 4'hF, 32'h55, 16'h7);
    set_lane(2, 1'b0, 30'd2, 4'h0, 32'h0, 16'h2);
    step();
    chk("t5_c0", obs_ready, 4'b0001);
    step();
    chk("t5_c1", obs_ready, 4'b0010);
    step();
    chk("t5_c2", obs_ready, 4'b0100);
    drain(16);

    // Reset with reads in flight.
    rsp_ready = 1'b0;
    set_lane(0, 1'b0, 30'd0, 4'h0, 32'h0, 16'h60);
    step();
    set_lane(0, 1'b0, 30'd1, 4'h0, 32'h0, 16'h61);
    step();
    set_lane(0, 1'b0, 30'd2, 4'h0, 32'h0, 16'h62);
    reset = 1'b1;
    #1;
    chk("t6_rsp_valid", rsp_valid, 1'b0);
    chk("t6_req_ready", req_ready, '0);
    chk("t6_perf", perf_conflicts, '0);
    q.delete();
    perf_m = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc += 2;
    req_valid = '0;
    reset = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) step();
    rsp_ready = 1'b0;
    for (int k = 0; k < QS; k++) begin
      set_lane(0, 1'b0, ADDRW'(k), 4'h0, 32'h0, 16'h70 + 16'(k));
      step();
      chk("t6_credit_grant", obs_ready, 4'b0001);
    end
    drain(32);

    // Randomized traffic over an initialised 64-word region.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < NT; i++) set_lane(i, 1'b1, ADDRW'(4*k + i), 4'hF, $urandom, 16'h77);
      issue(4);
    end
    for (int n = 0; n < 300; n++) begin
      if (req_valid == '0) begin
        for (int i = 0; i < NT; i++) begin
          if ($urandom_range(3) != 0) begin
            r = $urandom;
            set_lane(i, ($urandom_range(2) == 0), {r[29:10], 4'b0000, r[5:0]},
                     4'($urandom), $urandom, 16'($urandom_range(1)));
          end
        end
      end
      rsp_ready = ($urandom_range(3) != 0);
      step();
    end
    rsp_ready = 1'b1;
    issue(64);
    drain(64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
